// File: rtl/mux_sel_scheduler_if.sv
// Output handshake bundle of the mux select scheduler: captured mux data tagged
// with the requester index that produced it.
interface mux_sel_scheduler_if;
    logic       valid;
    logic       ready;
    logic [1:0] data;
    logic [4:0] idx;

    modport master (output valid, output data, output idx, input ready);
    modport slave  (input valid, input data, input idx, output ready);
endinterface

// File: rtl/mux_sel_scheduler.sv
// Round-robin arbiter driving the select of a 31:1 two-bit mux, capturing the
// mux output one cycle after the select settles and offering it on valid/ready.
//
// state   | meaning
// IDLE    | sel parked at 31, arbitrating among req when enabled
// CAPTURE | sel holds the winner for one cycle; mux output captured, gnt pulses
// HOLD    | captured data offered downstream until out_valid & out_ready
module mux_sel_scheduler (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [30:0]          req,
    input  logic [1:0]           mux_out,
    output logic [4:0]           sel,
    output logic [30:0]          gnt,
    output logic                 busy,
    mux_sel_scheduler_if.master  out_if
);
    localparam int         NUM_IN = 31;
    localparam logic [4:0] PARK   = 5'd31;
    localparam logic [4:0] LAST   = 5'd30;

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

    state_t     state, state_nx;
    logic [4:0] sel_nx;
    logic [4:0] last_ptr, last_ptr_nx;
    logic       out_valid, out_valid_nx;
    logic [1:0] out_data, out_data_nx;
    logic [4:0] out_idx, out_idx_nx;
    logic [4:0] winner;
    logic       found;

    // Search order starts just after the last grant; index 31 is never a candidate.
    always_comb begin
        logic [5:0] cand;
        winner = PARK;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = {1'b0, last_ptr} + 6'(k);
            if (cand >= 6'(NUM_IN))
                cand = cand - 6'(NUM_IN);
            if (!found && req[cand[4:0]]) begin
                winner = cand[4:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        sel_nx       = sel;
        last_ptr_nx  = last_ptr;
        out_valid_nx = out_valid;
        out_data_nx  = out_data;
        out_idx_nx   = out_idx;
        case (state)
            IDLE: begin
                if (enable && found) begin
                    sel_nx   = winner;
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                out_data_nx  = mux_out;
                out_idx_nx   = sel;
                out_valid_nx = 1'b1;
                last_ptr_nx  = sel;
                state_nx     = HOLD;
            end
            HOLD: begin
                if (out_valid && out_if.ready) begin
                    out_valid_nx = 1'b0;
                    sel_nx       = PARK;
                    state_nx     = IDLE;
                end
            end
            default: begin
                sel_nx       = PARK;
                out_valid_nx = 1'b0;
                state_nx     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= PARK;
            last_ptr  <= LAST;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            last_ptr  <= last_ptr_nx;
            out_valid <= out_valid_nx;
            out_data  <= out_data_nx;
            out_idx   <= out_idx_nx;
        end
    end

    assign gnt          = (state == CAPTURE) ? (31'(1) << sel) : '0;
    assign busy         = (state != IDLE);
    assign out_if.valid = out_valid;
    assign out_if.data  = out_data;
    assign out_if.idx   = out_idx;
endmodule
